// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci job front end.
package fib_pkg;

    localparam logic [31:0] FIB_N_MAX_32 = 32'd47;
    localparam int unsigned FIB_TAG_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_RESP
    } ctrl_state_t;

    typedef struct packed {
        logic [31:0]          n;
        logic [FIB_TAG_W-1:0] tag;
    } fib_req_t;

endpackage

// File: rtl/fib_req_fifo.sv
// Register FIFO with wrap-bit pointers; push and pop may coincide even when full.
module fib_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 36
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 wdata,
    input  logic                         pop,
    output logic [W-1:0]                 rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  diff;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: empty/full gate every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign diff  = wr_ptr - rd_ptr;
    assign count = CW'(diff);

endmodule

// File: rtl/fib_job_ctrl.sv
// Queues tagged n-values, runs them one at a time on the Fibonacci engine
// and returns tagged results in request order.
//
//   state      | meaning
//   IDLE       | waiting for a queued request; pops head into job registers
//   ISSUE      | one-cycle start pulse to the engine
//   WAIT_HI    | waiting for the engine to raise busy
//   WAIT_LO    | engine running; result captured when busy drops
//   RESP       | response held until the consumer accepts it
module fib_job_ctrl
    import fib_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = FIB_TAG_W,
    parameter logic [31:0] N_MAX = FIB_N_MAX_32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [31:0]                  req_n_i,
    input  logic [TAG_W-1:0]             req_tag_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [31:0]                  rsp_result_o,
    output logic [TAG_W-1:0]             rsp_tag_o,
    output logic                         rsp_err_o,
    output logic                         fib_start_o,
    output logic [31:0]                  fib_n_o,
    input  logic [31:0]                  fib_result_i,
    input  logic                         fib_busy_i,
    output logic [$clog2(DEPTH+1)-1:0]   pending_o
);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    fib_req_t         wr_req;
    fib_req_t         head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             range_err;
    logic             capture;
    logic [31:0]      job_n;
    logic [TAG_W-1:0] job_tag;
    logic [31:0]      rsp_result;
    logic             rsp_err;

    assign wr_req    = {req_n_i, req_tag_i};
    assign push      = req_valid_i && !fifo_full;
    assign range_err = (head.n > N_MAX);

    fib_req_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fib_req_t))
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .wdata (wr_req),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (!fifo_empty) state_nxt = range_err ? ST_RESP : ST_ISSUE;
            ST_ISSUE:   state_nxt = ST_WAIT_HI;
            ST_WAIT_HI: if (fib_busy_i)  state_nxt = ST_WAIT_LO;
            ST_WAIT_LO: if (!fib_busy_i) state_nxt = ST_RESP;
            ST_RESP:    if (rsp_ready_i) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pop         = (state == ST_IDLE) && !fifo_empty;
        fib_start_o = (state == ST_ISSUE);
        rsp_valid_o = (state == ST_RESP);
        capture     = (state == ST_WAIT_LO) && !fib_busy_i;
    end

    // Out-of-range jobs get their error response at pop time and never reach the engine.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            job_n      <= '0;
            job_tag    <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else if (pop) begin
            job_n      <= head.n;
            job_tag    <= head.tag;
            rsp_result <= '0;
            rsp_err    <= range_err;
        end else if (capture) begin
            rsp_result <= fib_result_i;
            rsp_err    <= 1'b0;
        end
    end

    assign req_ready_o  = !fifo_full;
    assign fib_n_o      = job_n;
    assign rsp_tag_o    = job_tag;
    assign rsp_result_o = rsp_result;
    assign rsp_err_o    = rsp_err;

endmodule

// File: tb/tb_fib_job_ctrl.sv
// Directed and randomized checks of fib_job_ctrl against a behavioural engine and result model.
module tb_fib_job_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_n;
    logic [3:0]  req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic        rsp_err;
    logic        fib_start;
    logic [31:0] fib_n;
    logic [31:0] fib_result;
    logic        fib_busy;
    logic [2:0]  pending;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    logic [31:0] eng_rem;
    logic [31:0] eng_n;

    logic [31:0] q_n[$];
    logic [3:0]  q_tag[$];

    fib_job_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_n_i      (req_n),
        .req_tag_i    (req_tag),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_tag_o    (rsp_tag),
        .rsp_err_o    (rsp_err),
        .fib_start_o  (fib_start),
        .fib_n_o      (fib_n),
        .fib_result_i (fib_result),
        .fib_busy_i   (fib_busy),
        .pending_o    (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fib_ref(input logic [31:0] n);
        logic [31:0] a = 32'd0;
        logic [31:0] b = 32'd1;
        logic [31:0] t;
        int k = (n > 32'd47) ? 47 : int'(n);
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine model: busy for max(1, n-1) cycles after start; result is junk until busy drops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fib_busy   <= 1'b0;
            eng_rem    <= 32'd0;
            eng_n      <= 32'd0;
            fib_result <= 32'd0;
        end else if (fib_start) begin
            fib_busy   <= 1'b1;
            eng_rem    <= (fib_n > 32'd1) ? fib_n - 32'd1 : 32'd1;
            eng_n      <= fib_n;
            fib_result <= $urandom;
        end else if (fib_busy) begin
            eng_rem <= eng_rem - 32'd1;
            if (eng_rem == 32'd1) begin
                fib_busy   <= 1'b0;
                fib_result <= fib_ref(eng_n);
            end
        end
    end

    always @(posedge clk) begin
        if (fib_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, ".req_ready"},  64'(req_ready),  64'd1);
        chk({name, ".rsp_valid"},  64'(rsp_valid),  64'd0);
        chk({name, ".fib_start"},  64'(fib_start),  64'd0);
        chk({name, ".rsp_err"},    64'(rsp_err),    64'd0);
        chk({name, ".rsp_result"}, 64'(rsp_result), 64'd0);
        chk({name, ".rsp_tag"},    64'(rsp_tag),    64'd0);
        chk({name, ".fib_n"},      64'(fib_n),      64'd0);
        chk({name, ".pending"},    64'(pending),    64'd0);
    endtask

    // Starts aligned #1 after a rising edge with the controller idle and the FIFO empty.
    task automatic run_job(input logic [31:0] n, input logic [3:0] tag, input string name);
        int          s0        = start_cnt;
        int          cyc;
        int          start_cyc = -1;
        logic        exp_err   = (n > 32'd47);
        logic [31:0] exp_res   = exp_err ? 32'd0 : fib_ref(n);
        int          exp_lat   = exp_err ? 2 : 4 + ((n > 32'd1) ? int'(n) - 1 : 1);
        req_valid = 1'b1;
        req_n     = n;
        req_tag   = tag;
        rsp_ready = 1'b1;
        chk({name, ".ready_before"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (cyc = 1; cyc < 200; cyc++) begin
            if (fib_start) begin
                start_cyc = cyc;
                chk({name, ".fib_n"}, 64'(fib_n), 64'(n));
            end
            if (rsp_valid) break;
            @(posedge clk);
            #1;
        end
        chk({name, ".latency"}, 64'(cyc), 64'(exp_lat));
        chk({name, ".result"},  64'(rsp_result), 64'(exp_res));
        chk({name, ".tag"},     64'(rsp_tag), 64'(tag));
        chk({name, ".err"},     64'(rsp_err), 64'(exp_err));
        chk({name, ".starts"},  64'(start_cnt - s0), exp_err ? 64'd0 : 64'd1);
        if (!exp_err) chk({name, ".start_cycle"}, 64'(start_cyc), 64'd2);
        @(posedge clk);
        #1;
        chk({name, ".valid_after_hs"}, 64'(rsp_valid), 64'd0);
        rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int k = 0;
        while (!rsp_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({name, ".rsp_timeout"}, 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        int          acc;
        int          k;
        logic        sampled;
        logic [31:0] hn;
        logic [3:0]  ht;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_n     = 32'd0;
        req_tag   = 4'd0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_job(32'd10, 4'hA, "n10");
        run_job(32'd0,  4'h1, "n0");
        run_job(32'd1,  4'h2, "n1");
        run_job(32'd2,  4'h3, "n2");
        run_job(32'd47, 4'h4, "n47");
        run_job(32'd48, 4'h5, "n48");
        run_job(32'hFFFF_FFFF, 4'h6, "nmax");
        for (int i = 0; i < 6; i++)
            run_job(32'($urandom_range(0, 60)), 4'($urandom_range(0, 15)), "rand");

        // Back-pressure: six offers with the consumer stalled.
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_n     = 32'($urandom_range(0, 12));
            req_tag   = 4'(i + 1);
            sampled   = req_ready;
            @(posedge clk);
            if (sampled) begin
                q_n.push_back(req_n);
                q_tag.push_back(req_tag);
                acc++;
            end
            #1;
        end
        chk("stall.accepted",  64'(acc), 64'd5);
        chk("stall.req_ready", 64'(req_ready), 64'd0);
        chk("stall.pending",   64'(pending), 64'd4);

        wait_rsp("stall");
        for (int i = 0; i < 4; i++) begin
            chk("stall.hold_valid",  64'(rsp_valid),  64'd1);
            chk("stall.hold_tag",    64'(rsp_tag),    64'(q_tag[0]));
            chk("stall.hold_result", 64'(rsp_result), 64'(fib_ref(q_n[0])));
            @(posedge clk);
            #1;
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        void'(q_n.pop_front());
        void'(q_tag.pop_front());
        chk("full.pending_at_pop", 64'(pending), 64'd4);
        chk("full.ready_at_pop",   64'(req_ready), 64'd0);
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("full.ready_returns", 64'(req_ready), 64'd1);
        @(posedge clk);
        q_n.push_back(req_n);
        q_tag.push_back(req_tag);
        #1;
        req_valid = 1'b0;
        chk("full.pending_refill", 64'(pending), 64'd4);

        rsp_ready = 1'b1;
        while (q_tag.size() > 0) begin
            hn = q_n.pop_front();
            ht = q_tag.pop_front();
            wait_rsp("drain");
            chk("drain.tag",    64'(rsp_tag),    64'(ht));
            chk("drain.result", 64'(rsp_result), 64'(fib_ref(hn)));
            chk("drain.err",    64'(rsp_err),    64'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b0;
        chk("drain.pending", 64'(pending), 64'd0);

        // Reset during WAIT_LO of n = 20, with a second request queued behind it.
        req_valid = 1'b1;
        req_n     = 32'd20;
        req_tag   = 4'h9;
        @(posedge clk);
        #1;
        req_n     = 32'd3;
        req_tag   = 4'h5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rstmid.fib_n",   64'(fib_n),   64'd20);
        chk("rstmid.pending", 64'(pending), 64'd1);
        k = start_cnt;
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("rstmid.async");
        @(posedge clk);
        #1;
        check_reset_vals("rstmid.held");
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rstmid.no_rsp",    64'(rsp_valid),     64'd0);
        chk("rstmid.no_start",  64'(start_cnt - k), 64'd0);
        chk("rstmid.empty",     64'(pending),       64'd0);
        rsp_ready = 1'b0;
        run_job(32'd7, 4'h3, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
